// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory, redirect and decode-side signals of the fetch stage.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instruction;
    logic [6:0]  if_opcode;
    logic [31:0] if_pc;
    modport master (
        output imem_req, imem_addr, if_valid, if_instruction, if_opcode, if_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
    );
    modport slave (
        input  imem_req, imem_addr, if_valid, if_instruction, if_opcode, if_pc,
        output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: RV32 fetch stage with credit-limited imem requests, instruction FIFO and redirect flush.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input logic                 clk,
    input logic                 rst,
    instr_fetch_unit_if.master  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(FIFO_DEPTH - 1);

    logic [63:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d, infl_q, infl_d, disc_q, disc_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d, resp_pc_q, resp_pc_d, target;
    logic          valid, grant, push, pop, drop, req;
    logic [1:0]    unused_pc_lsb;

    function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
        return p == LAST ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        unused_pc_lsb = bus.redirect_pc[1:0];
        target        = {bus.redirect_pc[31:2], 2'b00};
        valid         = cnt_q != '0;
        // credit covers both buffered words and requests still awaiting a response
        req           = (({1'b0, cnt_q} + {1'b0, infl_q}) < DEPTH_C) && !bus.redirect_valid && !rst;
        grant         = req && bus.imem_gnt;
        drop          = bus.imem_rvalid && disc_q != '0;
        push          = bus.imem_rvalid && disc_q == '0 && !bus.redirect_valid;
        pop           = valid && bus.if_ready && !bus.redirect_valid;
        infl_d        = infl_q + CW'(grant) - CW'(bus.imem_rvalid);
        disc_d        = bus.redirect_valid ? infl_d : disc_q - CW'(drop);
        cnt_d         = bus.redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
        wr_d          = bus.redirect_valid ? '0 : push ? nxt(wr_q) : wr_q;
        rd_d          = bus.redirect_valid ? '0 : pop ? nxt(rd_q) : rd_q;
        fetch_pc_d    = bus.redirect_valid ? target : fetch_pc_q + (grant ? 32'd4 : 32'd0);
        resp_pc_d     = bus.redirect_valid ? target : resp_pc_q + (push ? 32'd4 : 32'd0);
        bus.imem_req       = req;
        bus.imem_addr      = fetch_pc_q;
        bus.if_valid       = valid;
        bus.if_instruction = valid ? mem_q[rd_q][31:0] : '0;
        bus.if_pc          = valid ? mem_q[rd_q][63:32] : '0;
        bus.if_opcode      = bus.if_instruction[6:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            cnt_q      <= '0;
            infl_q     <= '0;
            disc_q     <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            cnt_q      <= cnt_d;
            infl_q     <= infl_d;
            disc_q     <= disc_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= {resp_pc_q, bus.imem_rdata};
    end
endmodule
